// File: rtl/sdram_req_arbiter.sv
// Two-port round-robin arbiter in front of an SDRAM controller.
// It accepts one burst request, issues the command and counts data beats until done or timeout.
module sdram_req_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [LEN_W-1:0]  req_len0,
    input  logic [LEN_W-1:0]  req_len1,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LEN_W-1:0]  m_len,
    input  logic              m_beat,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int BC_W  = LEN_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BURST} state_t;

    state_t              state_reg;
    logic [1:0]          gnt_reg;
    logic [1:0]          done_reg;
    logic                err_reg;
    logic                m_valid_reg;
    logic                m_write_reg;
    logic [ADDR_W-1:0]   m_addr_reg;
    logic [LEN_W-1:0]    m_len_reg;
    logic [BC_W-1:0]     beat_cnt_reg;
    logic [CNT_W-1:0]    idle_cnt_reg;
    logic                last_reg;
    logic                armed_reg;

    logic                pick1;
    logic [1:0]          win_onehot;
    logic                accept_en;
    logic                accept;
    logic                idle_expired;
    logic                last_beat;

    // When both ports request, the one not granted last wins.
    assign pick1      = req_valid[1] && (!req_valid[0] || !last_reg);
    assign win_onehot = (req_valid == 2'b00) ? 2'b00 : (pick1 ? 2'b10 : 2'b01);
    // armed_reg holds off acceptance until one full edge after reset release.
    assign accept_en  = (state_reg == IDLE) && armed_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept_en && win_onehot[gi];
        end
    endgenerate

    assign accept       = |req_ready;
    assign idle_expired = (idle_cnt_reg == CNT_W'(TIMEOUT - 1));
    assign last_beat    = (beat_cnt_reg == {1'b0, m_len_reg});

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_reg    <= IDLE;
            gnt_reg      <= 2'b00;
            done_reg     <= 2'b00;
            err_reg      <= 1'b0;
            m_valid_reg  <= 1'b0;
            m_write_reg  <= 1'b0;
            m_addr_reg   <= '0;
            m_len_reg    <= '0;
            beat_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            last_reg     <= 1'b1;
            armed_reg    <= 1'b0;
        end else begin
            armed_reg <= 1'b1;
            done_reg  <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        gnt_reg      <= req_ready;
                        m_write_reg  <= pick1 ? req_write[1] : req_write[0];
                        m_addr_reg   <= pick1 ? req_addr1 : req_addr0;
                        m_len_reg    <= pick1 ? req_len1 : req_len0;
                        m_valid_reg  <= 1'b1;
                        idle_cnt_reg <= '0;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        m_valid_reg  <= 1'b0;
                        beat_cnt_reg <= '0;
                        idle_cnt_reg <= '0;
                        state_reg    <= BURST;
                    end else if (idle_expired) begin
                        m_valid_reg  <= 1'b0;
                        err_reg      <= 1'b1;
                        gnt_reg      <= 2'b00;
                        last_reg     <= gnt_reg[1];
                        idle_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
                    end
                end
                BURST: begin
                    if (m_beat) begin
                        idle_cnt_reg <= '0;
                        if (last_beat) begin
                            done_reg  <= gnt_reg;
                            gnt_reg   <= 2'b00;
                            last_reg  <= gnt_reg[1];
                            state_reg <= IDLE;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + BC_W'(1);
                        end
                    end else if (idle_expired) begin
                        err_reg      <= 1'b1;
                        gnt_reg      <= 2'b00;
                        last_reg     <= gnt_reg[1];
                        idle_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_valid = m_valid_reg;
    assign m_write = m_write_reg;
    assign m_addr  = m_addr_reg;
    assign m_len   = m_len_reg;
    assign gnt     = gnt_reg;
    assign done    = done_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: stimulus queues expected accepts, commands and
// completions; a negedge monitor pops and compares them as the DUT produces them.
module tb_sdram_req_arbiter;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = '0;
    logic [31:0] req_addr0 = '0;
    logic [31:0] req_addr1 = '0;
    logic [7:0]  req_len0 = '0;
    logic [7:0]  req_len1 = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_write;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic        m_beat = 1'b0;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;

    sdram_req_arbiter #(.ADDR_W(32), .LEN_W(8), .TIMEOUT(16)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_len0(req_len0), .req_len1(req_len1),
        .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write),
        .m_addr(m_addr), .m_len(m_len), .m_beat(m_beat),
        .gnt(gnt), .done(done), .err(err)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;

    logic [1:0]  exp_ready_q[$];
    logic [42:0] exp_cmd_q[$];   // {gnt, write, addr, len}
    logic [1:0]  exp_done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT-side event must match the head of its queue.
    always @(negedge ACLK) begin
        if (!ARST) begin
            if (req_ready != 2'b00) begin
                if (exp_ready_q.size() == 0) check("ready_unexpected", {62'd0, req_ready}, 64'd0);
                else check("ready", {62'd0, req_ready}, {62'd0, exp_ready_q.pop_front()});
                $display("accept: req_ready=%b", req_ready);
            end
            if (m_valid && m_ready) begin
                if (exp_cmd_q.size() == 0) check("cmd_unexpected", 64'd1, 64'd0);
                else check("cmd", {21'd0, gnt, m_write, m_addr, m_len}, {21'd0, exp_cmd_q.pop_front()});
                $display("command: gnt=%b write=%b addr=%h len=%0d", gnt, m_write, m_addr, m_len);
            end
            if (done != 2'b00) begin
                if (exp_done_q.size() == 0) check("done_unexpected", {62'd0, done}, 64'd0);
                else check("done", {62'd0, done}, {62'd0, exp_done_q.pop_front()});
                $display("done: %b", done);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {62'd0, req_ready}, 64'd0);
        check({tag, "_mvalid"}, {63'd0, m_valid}, 64'd0);
        check({tag, "_gnt"}, {62'd0, gnt}, 64'd0);
        check({tag, "_done"}, {62'd0, done}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, 64'd0);
        check({tag, "_fields"}, {23'd0, m_write, m_addr, m_len}, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        ARST = 1'b1;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge ACLK);
        #1 ARST = 1'b0;
    endtask

    // Issue one request on port p and hold it until accepted.
    task automatic send(input int p, input logic w, input logic [31:0] a,
                        input logic [7:0] l, input bit want_done);
        logic [1:0] oh;
        int n;
        oh = (p == 1) ? 2'b10 : 2'b01;
        exp_ready_q.push_back(oh);
        exp_cmd_q.push_back({oh, w, a, l});
        if (want_done) exp_done_q.push_back(oh);
        if (p == 1) begin req_addr1 = a; req_len1 = l; end
        else begin req_addr0 = a; req_len0 = l; end
        req_write[p] = w;
        req_valid[p] = 1'b1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!req_ready[p] && n < 60);
        if (!req_ready[p]) check("accept_wait", 64'd0, 64'd1);
        @(posedge ACLK);
        #1 req_valid[p] = 1'b0;
    endtask

    // Returns #1 after the edge that accepts the command (DUT now in BURST).
    task automatic wait_cmd();
        int n;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!(m_valid && m_ready) && n < 60);
        if (!(m_valid && m_ready)) check("cmd_wait", 64'd0, 64'd1);
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_beats(input int n, input logic [1:0] port_oh);
        m_beat = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge ACLK);
            #1;
            if (k == n) m_beat = 1'b0;
            check("done_at_beat", {62'd0, done}, (k == n) ? {62'd0, port_oh} : 64'd0);
        end
    endtask

    initial begin
        int seen;
        int n;

        // Reset state
        do_reset("rst0");

        // Single burst, port 0, len 3
        m_ready = 1'b1;
        send(0, 1'b0, 32'h100, 8'd3, 1'b1);
        check("gnt_issue", {62'd0, gnt}, 64'd1);
        wait_cmd();
        do_beats(4, 2'b01);
        @(posedge ACLK); #1;
        check("gnt_after", {62'd0, gnt}, 64'd0);

        // Round robin, both ports continuously, len 0
        do_reset("rst1");
        req_addr0 = 32'h200; req_len0 = 8'd0; req_write = 2'b10;
        req_addr1 = 32'h300; req_len1 = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                exp_ready_q.push_back(2'b01);
                exp_cmd_q.push_back({2'b01, 1'b0, 32'h200, 8'd0});
                exp_done_q.push_back(2'b01);
            end else begin
                exp_ready_q.push_back(2'b10);
                exp_cmd_q.push_back({2'b10, 1'b1, 32'h300, 8'd0});
                exp_done_q.push_back(2'b10);
            end
        end
        m_beat = 1'b1;
        req_valid = 2'b11;
        seen = 0;
        n = 0;
        while (seen < 4 && n < 100) begin
            @(negedge ACLK);
            n++;
            if (req_ready != 2'b00) seen++;
        end
        check("rr_grants_seen", seen, 4);
        @(posedge ACLK);
        #1 req_valid = 2'b00;
        repeat (4) @(posedge ACLK);
        #1 m_beat = 1'b0;

        // Stalled command: fields stable while m_ready is low
        m_ready = 1'b0;
        send(1, 1'b1, 32'h1234_5678, 8'd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("stall_mvalid", {63'd0, m_valid}, 64'd1);
            check("stall_fields", {23'd0, m_write, m_addr, m_len}, {23'd0, 1'b1, 32'h1234_5678, 8'd5});
        end
        @(posedge ACLK);
        #1 m_ready = 1'b1;
        wait_cmd();
        check("burst_mvalid", {63'd0, m_valid}, 64'd0);
        do_beats(6, 2'b10);

        // Timeout after accept with no beats
        send(0, 1'b0, 32'h400, 8'd2, 1'b0);
        wait_cmd();
        repeat (15) @(posedge ACLK);
        #1 check("err_before_timeout", {63'd0, err}, 64'd0);
        @(posedge ACLK);
        #1;
        check("err_at_timeout", {63'd0, err}, 64'd1);
        check("gnt_at_timeout", {62'd0, gnt}, 64'd0);
        send(1, 1'b1, 32'h500, 8'd1, 1'b1);
        wait_cmd();
        do_beats(2, 2'b10);
        check("err_sticky", {63'd0, err}, 64'd1);

        // Maximum length: done on beat 256 exactly
        send(0, 1'b0, 32'h600, 8'd255, 1'b1);
        wait_cmd();
        do_beats(256, 2'b01);

        // Reset mid-burst, then port 0 priority restored
        send(1, 1'b0, 32'h700, 8'd7, 1'b0);
        wait_cmd();
        m_beat = 1'b1;
        @(posedge ACLK);
        #1 ARST = 1'b1;
        m_beat = 1'b0;
        #1 check_reset_outputs("rst_mid");
        req_addr0 = 32'h800; req_len0 = 8'd0; req_write = 2'b00;
        req_addr1 = 32'h900; req_len1 = 8'd0;
        req_valid = 2'b11;
        exp_ready_q.push_back(2'b01);
        exp_cmd_q.push_back({2'b01, 1'b0, 32'h800, 8'd0});
        exp_done_q.push_back(2'b01);
        repeat (2) @(posedge ACLK);
        #1 check("ready_in_reset", {62'd0, req_ready}, 64'd0);
        ARST = 1'b0;
        @(negedge ACLK);
        check("ready_before_edge1", {62'd0, req_ready}, 64'd0);
        @(posedge ACLK);
        #1 check("ready_after_edge1", {62'd0, req_ready}, 64'd1);
        @(posedge ACLK);
        #1 req_valid = 2'b00;
        wait_cmd();
        do_beats(1, 2'b01);
        repeat (3) @(posedge ACLK);

        check("ready_q_empty", exp_ready_q.size(), 0);
        check("cmd_q_empty", exp_cmd_q.size(), 0);
        check("done_q_empty", exp_done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
